// File: rtl/note_judge_pkg.sv
// Shared definitions for the rhythm-game note judge and the LED controller:
// judge codes, game FSM encoding and score increments.
package note_judge_pkg;

    typedef enum logic [1:0] {
        JUDGE_NONE    = 2'b00,
        JUDGE_MISS    = 2'b01,
        JUDGE_NORMAL  = 2'b10,
        JUDGE_PERFECT = 2'b11
    } judge_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_OVER   = 2'b11
    } state_t;

    localparam logic [15:0] SCORE_PERFECT = 16'd3;
    localparam logic [15:0] SCORE_NORMAL  = 16'd1;
    localparam logic [15:0] SCORE_MISS    = 16'd0;

    function automatic logic [15:0] score_inc(input judge_t judge);
        logic [15:0] inc;
        case (judge)
            JUDGE_PERFECT: inc = SCORE_PERFECT;
            JUDGE_NORMAL:  inc = SCORE_NORMAL;
            default:       inc = SCORE_MISS;
        endcase
        return inc;
    endfunction

    // Score accumulation clamps at the top of the 16-bit range.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/note_judge_key_sync_edge.sv
// Brings the asynchronous player button into the clk domain and turns each
// press into a single-cycle pulse.
module key_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = sync2 & ~prev;

endmodule

// File: rtl/note_judge.sv
// Rhythm-game note judge: times button presses against a window centred on
// each note's target line and keeps score, combo and game-over state.
module note_judge
    import note_judge_pkg::*;
#(
    parameter int PERFECT_WIN = 30,
    parameter int NORMAL_WIN  = 100,
    parameter int HOLD_MS     = 200,
    parameter int TOTAL_NOTES = 64,
    parameter int MAX_MISS    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic        i_start,
    input  logic        i_note,
    input  logic        i_key,
    output logic [1:0]  o_judge,
    output logic        o_game_over,
    output logic [15:0] o_score,
    output logic [7:0]  o_combo,
    output logic [7:0]  o_max_combo,
    output logic [1:0]  dbg_state
);

    localparam int WIN_LAST_I = 2 * NORMAL_WIN;
    localparam int WIN_W      = $clog2(WIN_LAST_I + 1);
    localparam int HOLD_W     = $clog2(HOLD_MS + 1);
    localparam int NOTE_W     = $clog2(TOTAL_NOTES + 1);
    localparam int MISS_W     = $clog2(MAX_MISS + 1);

    localparam logic [WIN_W-1:0] WIN_CENTER = WIN_W'(NORMAL_WIN);
    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WIN_LAST_I);
    localparam logic [WIN_W-1:0] PERFECT_D  = WIN_W'(PERFECT_WIN);

    state_t            state;
    state_t            state_next;
    logic [WIN_W-1:0]  win_cnt;
    logic [WIN_W-1:0]  win_next;
    logic [WIN_W-1:0]  win_dist;
    logic              press;
    logic              judge_fire;
    judge_t            judge_code;
    judge_t            judge_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [NOTE_W-1:0] note_cnt;
    logic [MISS_W-1:0] miss_cnt;
    logic              last_note;
    logic              last_miss;
    logic [7:0]        combo_up;

    key_sync_edge u_key (
        .clk   (clk),
        .rst   (rst),
        .key   (i_key),
        .press (press)
    );

    // Distance from the target line, in ms, of the note currently in flight.
    assign win_dist  = (win_cnt >= WIN_CENTER) ? (win_cnt - WIN_CENTER)
                                               : (WIN_CENTER - win_cnt);
    assign last_note = (note_cnt == NOTE_W'(TOTAL_NOTES - 1));
    assign last_miss = (miss_cnt == MISS_W'(MAX_MISS - 1));
    assign combo_up  = (o_combo == 8'hFF) ? 8'hFF : (o_combo + 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            win_cnt <= '0;
        end else begin
            state   <= state_next;
            win_cnt <= win_next;
        end
    end

    // A press always wins over a simultaneous note arrival or timeout; the
    // timeout fires on the tick that would carry win_cnt past WIN_LAST.
    always_comb begin
        state_next = state;
        win_next   = win_cnt;
        judge_fire = 1'b0;
        judge_code = JUDGE_NONE;
        if (i_start) begin
            state_next = ST_ARMED;
            win_next   = '0;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (i_note) begin
                        state_next = ST_ACTIVE;
                        win_next   = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (press) begin
                        judge_fire = 1'b1;
                        judge_code = (win_dist <= PERFECT_D) ? JUDGE_PERFECT : JUDGE_NORMAL;
                        if (i_note) begin
                            win_next = '0;
                        end else begin
                            state_next = ST_ARMED;
                        end
                    end else if (i_note) begin
                        judge_fire = 1'b1;
                        judge_code = JUDGE_MISS;
                        win_next   = '0;
                    end else if (i_tick) begin
                        if (win_cnt == WIN_LAST) begin
                            judge_fire = 1'b1;
                            judge_code = JUDGE_MISS;
                            state_next = ST_ARMED;
                        end else begin
                            win_next = win_cnt + WIN_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
            if (judge_fire && (last_note || ((judge_code == JUDGE_MISS) && last_miss))) begin
                state_next = ST_OVER;
            end
        end
    end

    // Judgement display: reload on every judgement, count down on ticks,
    // and keep running in OVER so the final judgement completes its hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            judge_q  <= JUDGE_NONE;
            hold_cnt <= '0;
        end else if (i_start) begin
            judge_q  <= JUDGE_NONE;
            hold_cnt <= '0;
        end else if (judge_fire) begin
            judge_q  <= judge_code;
            hold_cnt <= HOLD_W'(HOLD_MS);
        end else if (i_tick && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            if (hold_cnt == HOLD_W'(1)) begin
                judge_q <= JUDGE_NONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_score     <= '0;
            o_combo     <= '0;
            o_max_combo <= '0;
            note_cnt    <= '0;
            miss_cnt    <= '0;
        end else if (i_start) begin
            o_score     <= '0;
            o_combo     <= '0;
            o_max_combo <= '0;
            note_cnt    <= '0;
            miss_cnt    <= '0;
        end else if (judge_fire) begin
            o_score  <= sat_add16(o_score, score_inc(judge_code));
            note_cnt <= note_cnt + NOTE_W'(1);
            if (judge_code == JUDGE_MISS) begin
                o_combo  <= '0;
                miss_cnt <= miss_cnt + MISS_W'(1);
            end else begin
                o_combo <= combo_up;
                if (combo_up > o_max_combo) begin
                    o_max_combo <= combo_up;
                end
            end
        end
    end

    assign o_judge     = judge_q;
    assign o_game_over = (state == ST_OVER);
    assign dbg_state   = state;

endmodule
